// File: rtl/enemy_fire_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : enemy_fire_scheduler
// Purpose  : Chooses which alive enemy fires next and hands the shot to the
//            bullet unit. After a cooldown, columns are scanned round-robin
//            starting just after the last column that fired. The bottom-most
//            alive enemy of the first occupied column fires into the
//            lowest-index free bullet slot.
// Ports    : clk          - system clock, rising edge
//            reset        - synchronous, active-high
//            enable       - game running; low returns to WAIT
//            enemy_vivos  - alive mask, index = row*COLUNAS+col, row 0 top
//            slot_free    - bit i high = bullet slot i idle
//            fire_ready   - bullet unit accepts the shot
//            fire_valid   - shot request pending
//            fire_x/y     - shooter column / row
//            fire_slot    - bullet slot assigned to the shot
//            busy         - high while scanning or issuing
//            shots_fired  - accepted shots, saturating at 1023
// Revision : 1.0 - initial release
// ============================================================================
module enemy_fire_scheduler #(
    parameter int LINHAS   = 4,
    parameter int COLUNAS  = 8,
    parameter int N_SLOTS  = 2,
    parameter int COOLDOWN = 100000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [LINHAS*COLUNAS-1:0]   enemy_vivos,
    input  logic [N_SLOTS-1:0]          slot_free,
    input  logic                        fire_ready,
    output logic                        fire_valid,
    output logic [5:0]                  fire_x,
    output logic [5:0]                  fire_y,
    output logic [1:0]                  fire_slot,
    output logic                        busy,
    output logic [9:0]                  shots_fired
);

    localparam int                c_CNT_W    = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(COOLDOWN - 1);
    localparam logic [5:0]        c_LAST_COL = 6'(COLUNAS - 1);
    localparam logic [9:0]        c_SHOT_MAX = 10'd1023;

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_SCAN  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [5:0]           r_last_col;
    logic [5:0]           r_scan_col;
    logic [5:0]           r_miss_cnt;

    logic                 w_cnt_done;
    logic                 w_start_scan;
    logic                 w_latch_shot;
    logic                 w_handshake;
    logic [LINHAS-1:0]    w_col_bits;
    logic                 w_col_hit;
    logic [5:0]           w_hit_row;
    logic [1:0]           w_free_slot;
    logic [5:0]           w_first_col;
    logic [5:0]           w_next_col;

    assign w_cnt_done  = (r_cnt == c_CNT_MAX);
    assign w_first_col = (r_last_col == c_LAST_COL) ? 6'd0 : r_last_col + 6'd1;
    assign w_next_col  = (r_scan_col == c_LAST_COL) ? 6'd0 : r_scan_col + 6'd1;

    // Column under examination, one bit per row.
    always_comb begin
        w_col_bits = '0;
        for (int r = 0; r < LINHAS; r++) begin
            for (int c = 0; c < COLUNAS; c++) begin
                if (6'(c) == r_scan_col) begin
                    w_col_bits[r] = enemy_vivos[r*COLUNAS + c];
                end
            end
        end
    end

    assign w_col_hit = |w_col_bits;

    // Later rows overwrite earlier ones, leaving the bottom-most alive row.
    always_comb begin
        w_hit_row = 6'd0;
        for (int r = 0; r < LINHAS; r++) begin
            if (w_col_bits[r]) begin
                w_hit_row = 6'(r);
            end
        end
    end

    // Descending walk so the lowest free index wins.
    always_comb begin
        w_free_slot = 2'd0;
        for (int i = N_SLOTS - 1; i >= 0; i--) begin
            if (slot_free[i]) begin
                w_free_slot = 2'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_WAIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start_scan = 1'b0;
        w_latch_shot = 1'b0;
        w_handshake  = 1'b0;
        if (!enable) begin
            w_next_state = S_WAIT;
        end else begin
            case (r_state)
                S_WAIT: begin
                    if (w_cnt_done && (|slot_free) && (|enemy_vivos)) begin
                        w_next_state = S_SCAN;
                        w_start_scan = 1'b1;
                    end
                end
                S_SCAN: begin
                    if (w_col_hit) begin
                        // A hit with no free slot gives up the whole attempt.
                        if (|slot_free) begin
                            w_next_state = S_ISSUE;
                            w_latch_shot = 1'b1;
                        end else begin
                            w_next_state = S_WAIT;
                        end
                    end else if (r_miss_cnt == c_LAST_COL) begin
                        w_next_state = S_WAIT;
                    end
                end
                S_ISSUE: begin
                    if (fire_ready) begin
                        w_next_state = S_WAIT;
                        w_handshake  = 1'b1;
                    end
                end
                default: w_next_state = S_WAIT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            r_last_col  <= c_LAST_COL;
            r_scan_col  <= 6'd0;
            r_miss_cnt  <= 6'd0;
            fire_x      <= 6'd0;
            fire_y      <= 6'd0;
            fire_slot   <= 2'd0;
            shots_fired <= 10'd0;
        end else begin
            // Counter only runs while waiting with the game enabled; any
            // other situation restarts the cooldown from zero.
            if (!enable || (r_state != S_WAIT) || w_start_scan) begin
                r_cnt <= '0;
            end else if (!w_cnt_done) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            if (w_start_scan) begin
                r_scan_col <= w_first_col;
                r_miss_cnt <= 6'd0;
            end else if (enable && (r_state == S_SCAN) && !w_col_hit) begin
                r_scan_col <= w_next_col;
                r_miss_cnt <= r_miss_cnt + 6'd1;
            end

            if (w_latch_shot) begin
                fire_x    <= r_scan_col;
                fire_y    <= w_hit_row;
                fire_slot <= w_free_slot;
            end

            if (w_handshake) begin
                r_last_col <= fire_x;
                if (shots_fired != c_SHOT_MAX) begin
                    shots_fired <= shots_fired + 10'd1;
                end
            end
        end
    end

    assign fire_valid = (r_state == S_ISSUE);

    always_comb begin
        busy = (r_state == S_SCAN) || (r_state == S_ISSUE);
    end

endmodule
`default_nettype wire

// File: tb/tb_enemy_fire_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_enemy_fire_scheduler
// Purpose  : Self-checking bench for enemy_fire_scheduler (LINHAS=2,
//            COLUNAS=3, N_SLOTS=2, COOLDOWN=4). A behavioural model of the
//            firing rules runs alongside the design every cycle; directed
//            scenarios cover the latency, scan, slot, stall, enable and
//            saturation cases, followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_enemy_fire_scheduler;

    localparam int c_L  = 2;
    localparam int c_C  = 3;
    localparam int c_S  = 2;
    localparam int c_CD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [5:0] enemy_vivos;
    logic [1:0] slot_free;
    logic       fire_ready;
    logic       fire_valid;
    logic [5:0] fire_x;
    logic [5:0] fire_y;
    logic [1:0] fire_slot;
    logic       busy;
    logic [9:0] shots_fired;

    enemy_fire_scheduler #(
        .LINHAS   (c_L),
        .COLUNAS  (c_C),
        .N_SLOTS  (c_S),
        .COOLDOWN (c_CD)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .enemy_vivos (enemy_vivos),
        .slot_free   (slot_free),
        .fire_ready  (fire_ready),
        .fire_valid  (fire_valid),
        .fire_x      (fire_x),
        .fire_y      (fire_y),
        .fire_slot   (fire_slot),
        .busy        (busy),
        .shots_fired (shots_fired)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: activity is 0 idle/cooling, 1 looking, 2 offering.
    int m_act   = 0;
    int m_wait  = 0;   // cycles of cooldown elapsed
    int m_last  = c_C - 1;
    int m_col   = 0;
    int m_tried = 0;   // columns found empty in this attempt
    int m_x     = 0;
    int m_y     = 0;
    int m_slot  = 0;
    int m_shots = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        int row;
        int slot;
        bit hit;
        if (reset) begin
            m_act = 0; m_wait = 0; m_last = c_C - 1; m_col = 0; m_tried = 0;
            m_x = 0; m_y = 0; m_slot = 0; m_shots = 0;
        end else if (!enable) begin
            m_act = 0; m_wait = 0;
        end else if (m_act == 0) begin
            if (m_wait < c_CD - 1) begin
                m_wait++;
            end else if (slot_free != 0 && enemy_vivos != 0) begin
                m_act = 1; m_wait = 0; m_tried = 0;
                m_col = (m_last + 1) % c_C;
            end
        end else if (m_act == 1) begin
            hit = 0; row = 0;
            for (int r = 0; r < c_L; r++) begin
                if (enemy_vivos[r*c_C + m_col]) begin
                    hit = 1; row = r;
                end
            end
            slot = -1;
            for (int i = 0; i < c_S; i++) begin
                if (slot == -1 && slot_free[i]) slot = i;
            end
            if (hit) begin
                if (slot >= 0) begin
                    m_x = m_col; m_y = row; m_slot = slot; m_act = 2;
                end else begin
                    m_act = 0; m_wait = 0;
                end
            end else begin
                m_tried++;
                m_col = (m_col + 1) % c_C;
                if (m_tried == c_C) begin
                    m_act = 0; m_wait = 0;
                end
            end
        end else begin
            if (fire_ready) begin
                m_last = m_x;
                m_shots = (m_shots < 1023) ? m_shots + 1 : 1023;
                m_act = 0; m_wait = 0;
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("fire_valid", 32'(fire_valid), 32'(m_act == 2));
        check("busy", 32'(busy), 32'(m_act != 0));
        check("fire_x", 32'(fire_x), 32'(m_x));
        check("fire_y", 32'(fire_y), 32'(m_y));
        check("fire_slot", 32'(fire_slot), 32'(m_slot));
        check("shots_fired", 32'(shots_fired), 32'(m_shots));
    endtask

    // Runs until fire_valid is seen; n = cycles taken, n_scan = cycles busy
    // but not yet offering.
    task automatic wait_valid(input int bound, output int n, output int n_scan);
        n = 0;
        n_scan = 0;
        while (fire_valid !== 1'b1 && n < bound) begin
            cycle();
            n++;
            if (busy === 1'b1 && fire_valid !== 1'b1) n_scan++;
        end
        check("wait_valid", 32'(fire_valid), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            enable      = 1'($urandom);
            enemy_vivos = 6'($urandom);
            slot_free   = 2'($urandom);
            fire_ready  = 1'($urandom);
            cycle();
        end
        reset = 1'b0;
    endtask

    initial begin
        int n;
        int n_scan;
        int cnt;
        int shots_before;
        logic [5:0] hold_x;
        logic [5:0] hold_y;
        logic [1:0] hold_slot;

        reset = 1'b1; enable = 1'b0; enemy_vivos = '0; slot_free = '0; fire_ready = 1'b0;
        do_reset();
        check("reset_valid", 32'(fire_valid), 32'd0);
        check("reset_shots", 32'(shots_fired), 32'd0);

        // Full formation, every slot free, always ready.
        enable = 1'b1; enemy_vivos = 6'b111111; slot_free = 2'b11; fire_ready = 1'b1;
        wait_valid(20, n, n_scan);
        check("first_latency", 32'(n), 32'(c_CD + 1));
        check("first_x", 32'(fire_x), 32'd0);
        check("first_y", 32'(fire_y), 32'd1);
        check("first_slot", 32'(fire_slot), 32'd0);
        cycle();
        wait_valid(20, n, n_scan);
        check("second_x", 32'(fire_x), 32'd1);
        cycle();
        check("two_shots", 32'(shots_fired), 32'd2);

        // Single enemy in the last column: scan visits columns 0,1,2.
        do_reset();
        enable = 1'b1; enemy_vivos = 6'b000100; slot_free = 2'b11; fire_ready = 1'b1;
        wait_valid(20, n, n_scan);
        check("lone_scan_cycles", 32'(n_scan), 32'd3);
        check("lone_x", 32'(fire_x), 32'd2);
        check("lone_y", 32'(fire_y), 32'd0);
        cycle();

        // No enemies: never leaves WAIT.
        enemy_vivos = 6'b000000;
        shots_before = int'(shots_fired);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            cycle();
            if (busy !== 1'b0) cnt++;
        end
        check("empty_busy_cycles", 32'(cnt), 32'd0);
        check("empty_shots", 32'(shots_fired), 32'(shots_before));

        // No free slot for 20 cycles, then only slot 1 free. Ready held low
        // so the shot stalls in ISSUE for the next part.
        enemy_vivos = 6'b111111; slot_free = 2'b00; fire_ready = 1'b0;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (fire_valid !== 1'b0) cnt++;
        end
        check("noslot_valid_cycles", 32'(cnt), 32'd0);
        slot_free = 2'b10;
        wait_valid(20, n, n_scan);
        check("slot1_slot", 32'(fire_slot), 32'd1);

        // Stall with changing inputs: the offered shot must not move.
        hold_x = fire_x; hold_y = fire_y; hold_slot = fire_slot;
        shots_before = int'(shots_fired);
        for (int i = 0; i < 10; i++) begin
            enemy_vivos = 6'($urandom);
            slot_free   = 2'($urandom);
            cycle();
            check("stall_valid", 32'(fire_valid), 32'd1);
            check("stall_x", 32'(fire_x), 32'(hold_x));
            check("stall_y", 32'(fire_y), 32'(hold_y));
            check("stall_slot", 32'(fire_slot), 32'(hold_slot));
        end
        fire_ready = 1'b1;
        cycle();
        check("stall_release_valid", 32'(fire_valid), 32'd0);
        check("stall_release_shots", 32'(shots_fired), 32'(shots_before + 1));

        // Enable dropped while offering: shot discarded, cooldown restarts.
        enemy_vivos = 6'b111111; slot_free = 2'b11; fire_ready = 1'b0;
        wait_valid(20, n, n_scan);
        shots_before = int'(shots_fired);
        enable = 1'b0;
        cycle();
        check("disable_valid", 32'(fire_valid), 32'd0);
        check("disable_busy", 32'(busy), 32'd0);
        enable = 1'b1;
        wait_valid(20, n, n_scan);
        check("reenable_latency", 32'(n), 32'(c_CD + 1));
        check("disable_shots", 32'(shots_fired), 32'(shots_before));

        // Randomized traffic, including occasional reset and enable drops.
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 199) == 0);
            enable      = ($urandom_range(0, 15) != 0);
            enemy_vivos = ($urandom_range(0, 3) == 0) ? 6'd0 : 6'($urandom);
            slot_free   = 2'($urandom);
            fire_ready  = 1'($urandom);
            cycle();
        end

        // Sustained firing to reach the shot counter ceiling.
        do_reset();
        enable = 1'b1; enemy_vivos = 6'b111111; slot_free = 2'b11; fire_ready = 1'b1;
        for (int i = 0; i < 6400; i++) begin
            cycle();
        end
        check("shots_saturated", 32'(shots_fired), 32'd1023);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/enemy_fire_scheduler.md
ENEMY_FIRE_SCHEDULER -- requirements
Module: enemy_fire_scheduler

Interface
REQ-001 SHALL have parameter LINHAS, default 4, number of enemy rows (1..63).
REQ-002 SHALL have parameter COLUNAS, default 8, number of enemy columns (1..63).
REQ-003 SHALL have parameter N_SLOTS, default 2, number of enemy bullet slots (1..4).
REQ-004 SHALL have parameter COOLDOWN, default 100000, minimum cycles between shot attempts (>=1).
REQ-005 SHALL have port clk  in  1  single system clock; all state changes on rising edge.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port enable  in  1  game running; low forces WAIT.
REQ-008 SHALL have port enemy_vivos  in  LINHAS*COLUNAS  alive mask; index = row*COLUNAS+col, row 0 top.
REQ-009 SHALL have port slot_free  in  N_SLOTS  bit i high = bullet slot i idle.
REQ-010 SHALL have port fire_ready  in  1  bullet unit accepts the shot.
REQ-011 SHALL have port fire_valid  out  1  shot request pending.
REQ-012 SHALL have port fire_x  out  6  shooter column.
REQ-013 SHALL have port fire_y  out  6  shooter row.
REQ-014 SHALL have port fire_slot  out  2  bullet slot assigned.
REQ-015 SHALL have port busy  out  1  high in SCAN or ISSUE.
REQ-016 SHALL have port shots_fired  out  10  accepted shots, saturating.

Function
REQ-017 SHALL implement FSM states WAIT, SCAN, ISSUE.
REQ-018 WAIT: cooldown counter increments each enable-high cycle; at value COOLDOWN-1 with |slot_free and |enemy_vivos, go SCAN, counter cleared, scan_col = (last_col+1) mod COLUNAS; otherwise counter holds at COOLDOWN-1.
REQ-019 SCAN: one column examined per cycle; if any alive enemy in scan_col, latch fire_x=scan_col, fire_y=highest alive row (bottom-most), fire_slot=lowest-index free slot, go ISSUE.
REQ-020 SCAN miss: scan_col advances with wrap COLUNAS-1 -> 0; after COLUNAS consecutive misses go WAIT, counter cleared.
REQ-021 Slot chosen from slot_free sampled in the hit cycle; if slot_free is zero in that cycle, go WAIT without issuing.
REQ-022 ISSUE: fire_valid=1; fire_x/fire_y/fire_slot stable until handshake regardless of enemy_vivos/slot_free changes.
REQ-023 Handshake on cycle with fire_valid&fire_ready: last_col=fire_x, shots_fired+1 (saturate at 1023), go WAIT next cycle with fire_valid=0.
REQ-024 enable low in any state: next state WAIT, counter cleared, fire_valid=0 next cycle; shot discarded, shots_fired unchanged.
REQ-025 Latency: with enable high and first scanned column hit, fire_valid rises COOLDOWN+1 cycles after WAIT entry.
REQ-026 fire_x/fire_y upper unused bits SHALL be zero.
REQ-027 busy SHALL be combinational from state only.

Reset
REQ-028 reset SHALL dominate enable and handshake in the same cycle.
REQ-029 On reset: state WAIT, counter 0, last_col=COLUNAS-1, scan counters 0, fire_valid 0, fire_x/fire_y/fire_slot 0, busy 0, shots_fired 0.
REQ-030 Reset asserted mid-SCAN or mid-ISSUE SHALL abort with no shot counted.

Verification (LINHAS=2, COLUNAS=3, N_SLOTS=2, COOLDOWN=4)
REQ-031 Reset: hold reset 2 cycles with random inputs -> all outputs 0 next cycle.
REQ-032 enemy_vivos=6'b111111, slot_free=2'b11, ready=1, enable=1 -> fire_valid high 5 cycles after reset release, fire_x=0, fire_y=1, fire_slot=0; next shot fire_x=1, shots_fired=2.
REQ-033 enemy_vivos=6'b000100 -> SCAN 3 cycles, shot fire_x=2, fire_y=0; 6'b000000 -> never busy, no shot.
REQ-034 slot_free=2'b00 for 20 cycles -> fire_valid stays 0; then 2'b10 -> shot with fire_slot=1.
REQ-035 fire_ready=0 for 10 cycles in ISSUE while toggling enemy_vivos -> fire_valid/x/y/slot stable; ready=1 -> shots_fired +1, fire_valid 0 next cycle.
REQ-036 enable dropped during ISSUE -> fire_valid 0 next cycle, shots_fired unchanged, cooldown restarts from 0.
